mac_row_accumulator: RTL and testbench
======================================

// Module: mac_row_accumulator
// PURPOSE
//  Downstream stage of pipeline_4array_with_reduction. Consumes one reduced_vec per valid_reduced beat.
//  MAC mode: sums K_TILES partial vectors into one row-block result.
//  OUTER mode: passes each beat straight through.
//  Every result is round-shifted by FRAC_BITS, saturated to OUT_WIDTH and queued in a 2-entry output FIFO
//  with a valid/ready handshake toward writeback.
// PARAMETERS
//  TILE_SIZE   4    lanes per vector
//  ACC_WIDTH   32   width of incoming reduced_vec lanes
//  OUT_WIDTH   16   width of output lanes (signed, Q.FRAC_BITS)
//  FRAC_BITS   8    requantisation shift, >=1
//  K_TILES     16   partial vectors per row block (K/16)
//  TAG_WIDTH   8    row-block tag counter width
//  SUM_WIDTH   ACC_WIDTH+$clog2(K_TILES)   internal accumulator width (localparam)
// PORTS
//  clk            in   1                      clock, rising edge
//  rst_n          in   1                      async active-low reset
//  mode           in   3                      000=MAC, 011=OUTER, others=ignore input
//  valid_reduced  in   1                      reduced_vec valid this cycle
//  reduced_vec    in   [TILE_SIZE][ACC_WIDTH] signed partial sums
//  clear          in   1                      sync abort: drop partial sum, zero k-count; FIFO kept
//  out_valid      out  1                      FIFO head valid
//  out_ready      in   1                      consumer accepts head
//  out_vec        out  [TILE_SIZE][OUT_WIDTH] signed requantised result
//  out_tag        out  TAG_WIDTH              row-block index of head (OUTER: beat index)
//  busy           out  1                      accumulation in progress (k_cnt!=0)
//  err_ovf        out  1                      sticky: result dropped because FIFO full
//  err_mode       out  1                      sticky: mode changed while k_cnt!=0
// BEHAVIOUR
//  Reset values: all outputs 0; acc=0, k_cnt=0, tag=0, FIFO empty, state S_IDLE.
//  FSM:
//   - S_IDLE --(MAC & valid_reduced)--> S_ACC.
//   - S_ACC --(k_cnt==K_TILES-1 & valid)--> S_IDLE (emit).
//   - K_TILES==1 emits from S_IDLE directly.
//  MAC accumulation:
//   - valid beat adds sign-extended lanes to acc; k_cnt++.
//   - Final beat: result = acc + reduced_vec is written to FIFO next edge; acc and k_cnt zeroed.
//   - Gaps (valid_reduced=0) hold state.
//  OUTER: every valid beat is requantised and written; acc/k_cnt untouched.
//  Latency: final/OUTER beat at edge t -> out_valid=1 after edge t+1 when the FIFO was empty.
//  Requant, per lane:
//   - y = (x + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift).
//   - Clamp to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
//   - Rounding add done at SUM_WIDTH+1 so no wrap.
//  FIFO:
//   - Push and pop in the same cycle is legal when full (count unchanged).
//   - Push while full and no pop: result dropped, err_ovf=1.
//   - out_vec/out_tag stable while out_valid & !out_ready.
//  tag: increments per emitted result, wraps 2^TAG_WIDTH-1 -> 0; a dropped result still consumes a tag.
//  Mode change:
//   - Mode sampled each cycle.
//   - Leaving MAC with k_cnt!=0: partial dropped, k_cnt=0, err_mode=1.
//  clear: has priority over a same-cycle valid beat (beat discarded). Sticky errors are cleared only by rst_n.
//  Async reset mid-operation: immediate return to reset values, FIFO contents lost.
// CONFIGURATION
//  ROW_ACC_RELU_EN:
//   - Defined: negative lanes are forced to 0 after saturation, in both MAC and OUTER.
//   - Undefined: signed output is passed unchanged.
// STRUCTURE
//  Package cmamba_acc_pkg:
//   - mode_e (MODE_MAC=3'b000, MODE_OUTER=3'b011).
//   - Function requant_sat(x, FRAC_BITS, OUT_WIDTH).
//   - Lane vector typedefs.
//  Sub-module acc_out_fifo: 2-entry, vector + tag payload, valid/ready, full/empty flags.
// TESTING
//  T1 MAC: 16 beats, all lanes 256 -> one result, lanes = 16, tag 0, busy low after.
//  T2 MAC negative: 16 beats, lanes -384 -> lanes = -24; with ROW_ACC_RELU_EN -> 0.
//  T3 Saturation: 16 beats, lanes 0x7FFF0000 -> 32767; lanes 0x80000000 -> -32768.
//  T4 OUTER rounding: beats 384, 383, -128, -129 -> 2, 1, 0, -1; tags 0..3.
//  T5 Backpressure: out_ready=0, 3 OUTER beats -> 2 held, third dropped, err_ovf=1.
//     Then out_ready=1 -> first two drained in order.
//  T6 Abort paths:
//   - Mode->011 after 5 MAC beats -> err_mode=1, k_cnt=0.
//   - rst_n low after 7 beats -> all outputs 0.
//   - A fresh 16-beat block afterwards is correct.

Source files
------------

// File: rtl/cmamba_acc_pkg.sv
// Shared types and the per-lane requantisation helper for mac_row_accumulator.
package cmamba_acc_pkg;

    typedef enum logic [2:0] {
        MODE_MAC   = 3'b000,
        MODE_OUTER = 3'b011
    } mode_e;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_e;

    // Lanes are widened to this before rounding so the +half never wraps.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    function automatic wide_t requant_sat(input wide_t x, input int frac_bits, input int out_width);
        wide_t rnd;
        wide_t hi;
        wide_t lo;
        rnd = (x + (wide_t'(1) <<< (frac_bits - 1))) >>> frac_bits;
        hi  = (wide_t'(1) <<< (out_width - 1)) - wide_t'(1);
        lo  = -(wide_t'(1) <<< (out_width - 1));
        if (rnd > hi) return hi;
        if (rnd < lo) return lo;
        return rnd;
    endfunction

endpackage

// File: rtl/acc_out_fifo.sv
// Two-entry FIFO carrying requantised row results (vector + tag) toward writeback.
module acc_out_fifo #(
    parameter int W = 72
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] din_i,
    input  logic         pop_i,
    output logic [W-1:0] dout_o,
    output logic         full_o,
    output logic         empty_o
);
    logic [W-1:0] mem_q [2];
    logic         wr_ptr_q;
    logic         rd_ptr_q;
    logic [1:0]   cnt_q;
    logic         do_pop;
    logic         do_push;

    assign full_o  = (cnt_q == 2'd2);
    assign empty_o = (cnt_q == 2'd0);
    assign dout_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    // A full FIFO still takes a push when the head leaves on the same edge.
    assign do_push = push_i & (~full_o | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q[0] <= '0;
            mem_q[1] <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= din_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (do_pop) rd_ptr_q <= ~rd_ptr_q;
            cnt_q <= cnt_q + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/mac_row_accumulator.sv
// Accumulates K_TILES reduced vectors (MAC) or passes beats through (OUTER), then requantises into a 2-deep FIFO.
// Optional macro ROW_ACC_RELU_EN forces negative output lanes to zero.
module mac_row_accumulator
    import cmamba_acc_pkg::*;
#(
    parameter int TILE_SIZE = 4,
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8,
    parameter int K_TILES   = 16,
    parameter int TAG_WIDTH = 8
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic [2:0]                           mode,
    input  logic                                 valid_reduced,
    input  logic [TILE_SIZE-1:0][ACC_WIDTH-1:0]  reduced_vec,
    input  logic                                 clear,
    output logic                                 out_valid,
    input  logic                                 out_ready,
    output logic [TILE_SIZE-1:0][OUT_WIDTH-1:0]  out_vec,
    output logic [TAG_WIDTH-1:0]                 out_tag,
    output logic                                 busy,
    output logic                                 err_ovf,
    output logic                                 err_mode
);
    localparam int SUM_WIDTH = ACC_WIDTH + $clog2(K_TILES);
    localparam int KW        = (K_TILES > 1) ? $clog2(K_TILES) : 1;
    localparam int PAY_W     = TAG_WIDTH + TILE_SIZE * OUT_WIDTH;

    state_e                        state_q, state_d;
    logic [KW-1:0]                 k_cnt_q, k_cnt_d;
    logic signed [SUM_WIDTH-1:0]   acc_q [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0]   acc_d [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0]   beat_ext [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0]   sum [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0]   res_p0_q [TILE_SIZE];
    logic signed [SUM_WIDTH-1:0]   res_d [TILE_SIZE];
    logic                          vld_p0_q, vld_d;
    logic [TAG_WIDTH-1:0]          tag_q;
    logic                          err_mode_q, err_mode_d;
    logic                          err_ovf_q;
    logic [TILE_SIZE-1:0][OUT_WIDTH-1:0] q_lane;
    logic [PAY_W-1:0]              fifo_dout;
    logic                          fifo_full;
    logic                          fifo_empty;

    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            beat_ext[i] = SUM_WIDTH'($signed(reduced_vec[i]));
            sum[i]      = acc_q[i] + beat_ext[i];
        end
    end

    // Stage p0: accept beat, update accumulator, capture full-precision result
    always_comb begin
        state_d    = state_q;
        k_cnt_d    = k_cnt_q;
        acc_d      = acc_q;
        res_d      = res_p0_q;
        vld_d      = 1'b0;
        err_mode_d = err_mode_q;
        if (clear) begin
            state_d = S_IDLE;
            k_cnt_d = '0;
            acc_d   = '{default: '0};
        end else if (mode == MODE_MAC) begin
            if (valid_reduced) begin
                if (k_cnt_q == KW'(K_TILES - 1)) begin
                    res_d   = sum;
                    vld_d   = 1'b1;
                    acc_d   = '{default: '0};
                    k_cnt_d = '0;
                    state_d = S_IDLE;
                end else begin
                    acc_d   = sum;
                    k_cnt_d = k_cnt_q + KW'(1);
                    state_d = S_ACC;
                end
            end
        end else begin
            if (k_cnt_q != '0) begin
                err_mode_d = 1'b1;
                acc_d      = '{default: '0};
                k_cnt_d    = '0;
                state_d    = S_IDLE;
            end
            if (mode == MODE_OUTER && valid_reduced) begin
                res_d = beat_ext;
                vld_d = 1'b1;
            end
        end
    end

    // Stage p1: requantise and push into the output FIFO
    always_comb begin
        for (int i = 0; i < TILE_SIZE; i++) begin
            q_lane[i] = OUT_WIDTH'(requant_sat(wide_t'(res_p0_q[i]), FRAC_BITS, OUT_WIDTH));
`ifdef ROW_ACC_RELU_EN
            if (q_lane[i][OUT_WIDTH-1]) q_lane[i] = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            k_cnt_q    <= '0;
            vld_p0_q   <= 1'b0;
            tag_q      <= '0;
            err_mode_q <= 1'b0;
            err_ovf_q  <= 1'b0;
            for (int i = 0; i < TILE_SIZE; i++) begin
                acc_q[i]    <= '0;
                res_p0_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            k_cnt_q    <= k_cnt_d;
            acc_q      <= acc_d;
            res_p0_q   <= res_d;
            vld_p0_q   <= vld_d;
            err_mode_q <= err_mode_d;
            // A result dropped on a full FIFO still consumes its tag.
            if (vld_p0_q) begin
                tag_q <= tag_q + TAG_WIDTH'(1);
                if (fifo_full && !out_ready) err_ovf_q <= 1'b1;
            end
        end
    end

    acc_out_fifo #(.W(PAY_W)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (vld_p0_q),
        .din_i   ({tag_q, q_lane}),
        .pop_i   (out_ready),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign {out_tag, out_vec} = fifo_dout;
    assign out_valid = ~fifo_empty;
    assign busy      = (state_q == S_ACC);
    assign err_ovf   = err_ovf_q;
    assign err_mode  = err_mode_q;

endmodule

// File: tb/tb_mac_row_accumulator.sv
// Directed bench for mac_row_accumulator: transaction-level model plus hand-computed expectations.
module tb_mac_row_accumulator;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [2:0]       mode;
    logic             valid_reduced;
    logic [3:0][31:0] reduced_vec;
    logic             clear;
    logic             out_valid;
    logic             out_ready;
    logic [3:0][15:0] out_vec;
    logic [7:0]       out_tag;
    logic             busy;
    logic             err_ovf;
    logic             err_mode;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    typedef struct packed {
        logic [63:0] vec;
        logic [7:0]  tag;
    } ent_t;

    ent_t        mq[$];
    ent_t        got[$];
    longint      m_acc[4];
    int          m_k = 0;
    logic [7:0]  m_tag = 8'd0;
    bit          m_pend = 1'b0;
    logic [63:0] m_pvec = '0;
    bit          m_ovf = 1'b0;
    bit          m_emode = 1'b0;

    mac_row_accumulator dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .mode          (mode),
        .valid_reduced (valid_reduced),
        .reduced_vec   (reduced_vec),
        .clear         (clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_vec       (out_vec),
        .out_tag       (out_tag),
        .busy          (busy),
        .err_ovf       (err_ovf),
        .err_mode      (err_mode)
    );

    always #5 clk = ~clk;

    // Round half up by floor division, clamp to int16, optional ReLU.
    function automatic logic [15:0] tb_rq(input longint x);
        longint n;
        longint y;
        n = x + 128;
        if (n >= 0) y = n / 256;
        else        y = -((-n + 255) / 256);
        if (y > 32767)  y = 32767;
        if (y < -32768) y = -32768;
`ifdef ROW_ACC_RELU_EN
        if (y < 0) y = 0;
`endif
        return y[15:0];
    endfunction

    function automatic logic [3:0][31:0] v4(input int a, input int b, input int c, input int d);
        logic [3:0][31:0] v;
        v[0] = a; v[1] = b; v[2] = c; v[3] = d;
        return v;
    endfunction

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // Model: results from the arithmetic rules, queued in a 2-deep FIFO one edge after the final beat.
    initial begin
        foreach (m_acc[l]) m_acc[l] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                foreach (m_acc[l]) m_acc[l] = 0;
                m_k = 0; m_tag = 8'd0; m_pend = 1'b0; m_ovf = 1'b0; m_emode = 1'b0;
            end else begin
                if (mq.size() > 0 && out_ready) mq.delete(0);
                if (m_pend) begin
                    if (mq.size() < 2) mq.push_back({m_pvec, m_tag});
                    else m_ovf = 1'b1;
                    m_tag = m_tag + 8'd1;
                end
                m_pend = 1'b0;
                if (clear) begin
                    m_k = 0;
                    foreach (m_acc[l]) m_acc[l] = 0;
                end else if (mode == 3'b000) begin
                    if (valid_reduced) begin
                        foreach (m_acc[l]) m_acc[l] += longint'($signed(reduced_vec[l]));
                        m_k++;
                        if (m_k == 16) begin
                            foreach (m_acc[l]) m_pvec[l*16 +: 16] = tb_rq(m_acc[l]);
                            m_pend = 1'b1;
                            m_k = 0;
                            foreach (m_acc[l]) m_acc[l] = 0;
                        end
                    end
                end else begin
                    if (m_k != 0) begin
                        m_emode = 1'b1;
                        m_k = 0;
                        foreach (m_acc[l]) m_acc[l] = 0;
                    end
                    if (mode == 3'b011 && valid_reduced) begin
                        for (int l = 0; l < 4; l++) m_pvec[l*16 +: 16] = tb_rq(longint'($signed(reduced_vec[l])));
                        m_pend = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (cmp_en) begin
                chk("out_valid", 72'(out_valid), 72'(mq.size() > 0));
                if (out_valid && mq.size() > 0) chk("out_head", {out_vec, out_tag}, mq[0]);
                chk("busy", 72'(busy), 72'(m_k != 0));
                chk("err_ovf", 72'(err_ovf), 72'(m_ovf));
                chk("err_mode", 72'(err_mode), 72'(m_emode));
                if (rst_n && out_valid && out_ready) got.push_back({out_vec, out_tag});
            end
        end
    end

    task automatic beat(input logic [2:0] md, input logic [3:0][31:0] v);
        mode = md; valid_reduced = 1'b1; reduced_vec = v;
        @(negedge clk);
        valid_reduced = 1'b0;
    endtask

    task automatic block(input logic [3:0][31:0] v);
        for (int i = 0; i < 16; i++) beat(3'b000, v);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        got.delete();
        #1;
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_out_vec", 72'(out_vec), 72'd0);
        chk("rst_out_tag", 72'(out_tag), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_errs", {70'd0, err_ovf, err_mode}, 72'd0);
        @(negedge clk);
        rst_n = 1'b1; mode = 3'b000; clear = 1'b0; out_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic wait_got(input int n, input int limit);
        for (int i = 0; i < limit && got.size() < n; i++) @(negedge clk);
        chk("wait_results", 72'(got.size() >= n), 72'd1);
    endtask

    task automatic chk_got(input string nm, input int idx, input logic [63:0] vec, input logic [7:0] tag);
        if (got.size() <= idx) begin
            checks++; errors++;
            $display("FAIL %s actual=missing expected=%0h", nm, {vec, tag});
        end else begin
            chk(nm, got[idx], {vec, tag});
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; mode = 3'b000; valid_reduced = 1'b0;
        reduced_vec = '0; out_ready = 1'b1;
        @(negedge clk);
        cmp_en = 1'b1;
        do_reset();

        // T1: 16 x 256 -> 4096 -> 16
        block(v4(256, 256, 256, 256));
        wait_got(1, 10);
        chk_got("t1_mac", 0, pk(16, 16, 16, 16), 8'd0);
        chk("t1_busy_after", 72'(busy), 72'd0);

        // T2: 16 x -384 -> -6144 -> -24
        do_reset();
        block(v4(-384, -384, -384, -384));
        wait_got(1, 10);
`ifdef ROW_ACC_RELU_EN
        chk_got("t2_mac_neg", 0, pk(0, 0, 0, 0), 8'd0);
`else
        chk_got("t2_mac_neg", 0, pk(-24, -24, -24, -24), 8'd0);
`endif

        // T3: saturation both ways, back-to-back blocks
        do_reset();
        block(v4(32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000, 32'h7FFF0000));
        block(v4(32'h80000000, 32'h80000000, 32'h80000000, 32'h80000000));
        wait_got(2, 10);
        chk_got("t3_sat_pos", 0, pk(32767, 32767, 32767, 32767), 8'd0);
`ifdef ROW_ACC_RELU_EN
        chk_got("t3_sat_neg", 1, pk(0, 0, 0, 0), 8'd1);
`else
        chk_got("t3_sat_neg", 1, pk(-32768, -32768, -32768, -32768), 8'd1);
`endif

        // T4: OUTER rounding
        do_reset();
        beat(3'b011, v4(384, 384, 384, 384));
        beat(3'b011, v4(383, 383, 383, 383));
        beat(3'b011, v4(-128, -128, -128, -128));
        beat(3'b011, v4(-129, -129, -129, -129));
        wait_got(4, 10);
        chk_got("t4_r384", 0, pk(2, 2, 2, 2), 8'd0);
        chk_got("t4_r383", 1, pk(1, 1, 1, 1), 8'd1);
        chk_got("t4_rm128", 2, pk(0, 0, 0, 0), 8'd2);
`ifdef ROW_ACC_RELU_EN
        chk_got("t4_rm129", 3, pk(0, 0, 0, 0), 8'd3);
`else
        chk_got("t4_rm129", 3, pk(-1, -1, -1, -1), 8'd3);
`endif

        // T5: backpressure, third result dropped
        do_reset();
        out_ready = 1'b0;
        beat(3'b011, v4(256, 256, 256, 256));
        beat(3'b011, v4(512, 512, 512, 512));
        beat(3'b011, v4(768, 768, 768, 768));
        repeat (2) @(negedge clk);
        chk("t5_err_ovf", 72'(err_ovf), 72'd1);
        chk("t5_held_head", {out_vec, out_tag}, {pk(1, 1, 1, 1), 8'd0});
        out_ready = 1'b1;
        wait_got(2, 10);
        chk_got("t5_drain0", 0, pk(1, 1, 1, 1), 8'd0);
        chk_got("t5_drain1", 1, pk(2, 2, 2, 2), 8'd1);
        repeat (2) @(negedge clk);
        chk("t5_empty", 72'(out_valid), 72'd0);

        // T6a: leave MAC mid-block
        do_reset();
        for (int i = 0; i < 5; i++) beat(3'b000, v4(256, 256, 256, 256));
        chk("t6_busy_mid", 72'(busy), 72'd1);
        mode = 3'b011;
        @(negedge clk);
        chk("t6_err_mode", 72'(err_mode), 72'd1);
        chk("t6_busy_abort", 72'(busy), 72'd0);
        mode = 3'b000;

        // clear drops the partial and the same-cycle beat
        do_reset();
        for (int i = 0; i < 3; i++) beat(3'b000, v4(256, 256, 256, 256));
        clear = 1'b1;
        beat(3'b000, v4(256, 256, 256, 256));
        clear = 1'b0;
        block(v4(512, 512, 512, 512));
        wait_got(1, 10);
        chk_got("clr_block", 0, pk(32, 32, 32, 32), 8'd0);
        chk("clr_no_err", 72'(err_mode), 72'd0);

        // T6b: async reset after 7 beats, then a fresh block
        do_reset();
        for (int i = 0; i < 7; i++) beat(3'b000, v4(256, 256, 256, 256));
        do_reset();
        block(v4(100, -50, 1000, 7));
        wait_got(1, 10);
`ifdef ROW_ACC_RELU_EN
        chk_got("t6_fresh", 0, pk(6, 0, 63, 0), 8'd0);
`else
        chk_got("t6_fresh", 0, pk(6, -3, 63, 0), 8'd0);
`endif
        repeat (3) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
